// File: rtl/axi_wr_arbiter.sv
// Round-robin arbiter funnelling NUM_REQ AXI4 write requesters onto a single AXI4 write master.
// One requester owns the master from its AW grant until its B handshake completes.
module axi_wr_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 512,
    parameter int ID_WIDTH   = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_REQ*ID_WIDTH-1:0]       s_axi_awid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]     s_axi_awaddr,
    input  logic [NUM_REQ*8-1:0]              s_axi_awlen,
    input  logic [NUM_REQ*3-1:0]              s_axi_awsize,
    input  logic [NUM_REQ*2-1:0]              s_axi_awburst,
    input  logic [NUM_REQ-1:0]                s_axi_awvalid,
    output logic [NUM_REQ-1:0]                s_axi_awready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]     s_axi_wdata,
    input  logic [NUM_REQ*(DATA_WIDTH/8)-1:0] s_axi_wstrb,
    input  logic [NUM_REQ-1:0]                s_axi_wlast,
    input  logic [NUM_REQ-1:0]                s_axi_wvalid,
    output logic [NUM_REQ-1:0]                s_axi_wready,
    output logic [NUM_REQ*ID_WIDTH-1:0]       s_axi_bid,
    output logic [NUM_REQ*2-1:0]              s_axi_bresp,
    output logic [NUM_REQ-1:0]                s_axi_bvalid,
    input  logic [NUM_REQ-1:0]                s_axi_bready,
    output logic [ID_WIDTH-1:0]               m_axi_awid,
    output logic [ADDR_WIDTH-1:0]             m_axi_awaddr,
    output logic [7:0]                        m_axi_awlen,
    output logic [2:0]                        m_axi_awsize,
    output logic [1:0]                        m_axi_awburst,
    output logic                              m_axi_awvalid,
    input  logic                              m_axi_awready,
    output logic [DATA_WIDTH-1:0]             m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0]           m_axi_wstrb,
    output logic                              m_axi_wlast,
    output logic                              m_axi_wvalid,
    input  logic                              m_axi_wready,
    input  logic [ID_WIDTH-1:0]               m_axi_bid,
    input  logic [1:0]                        m_axi_bresp,
    input  logic                              m_axi_bvalid,
    output logic                              m_axi_bready,
    output logic                              len_err,
    output logic [$clog2(NUM_REQ)-1:0]        grant_idx
);
    localparam int GW = $clog2(NUM_REQ);
    localparam int SW = DATA_WIDTH / 8;
    localparam logic [GW:0]   NUM_REQ_W = (GW+1)'(NUM_REQ);
    localparam logic [GW-1:0] LAST_IDX  = GW'(NUM_REQ - 1);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_e;

    state_e        state_q, state_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [GW-1:0] rr_ptr_q, rr_ptr_d;
    logic [8:0]    beat_cnt_q, beat_cnt_d;
    logic [7:0]    awlen_q, awlen_d;
    logic          len_err_q, len_err_d;

    logic [GW:0]   arb_sum;
    logic [GW-1:0] arb_cand;
    logic [GW-1:0] arb_idx;
    logic          arb_found;
    logic [8:0]    beat_next;
    logic [8:0]    exp_beats;

    // Scan requesters starting at rr_ptr, wrapping modulo NUM_REQ; first valid one wins.
    always_comb begin
        arb_sum   = '0;
        arb_cand  = '0;
        arb_idx   = '0;
        arb_found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            arb_sum = {1'b0, rr_ptr_q} + (GW+1)'(i);
            if (arb_sum >= NUM_REQ_W) arb_sum = arb_sum - NUM_REQ_W;
            arb_cand = arb_sum[GW-1:0];
            if (!arb_found && s_axi_awvalid[arb_cand]) begin
                arb_found = 1'b1;
                arb_idx   = arb_cand;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        awlen_d    = awlen_q;
        len_err_d  = len_err_q;

        m_axi_awid    = s_axi_awid[grant_q*ID_WIDTH +: ID_WIDTH];
        m_axi_awaddr  = s_axi_awaddr[grant_q*ADDR_WIDTH +: ADDR_WIDTH];
        m_axi_awlen   = s_axi_awlen[grant_q*8 +: 8];
        m_axi_awsize  = s_axi_awsize[grant_q*3 +: 3];
        m_axi_awburst = s_axi_awburst[grant_q*2 +: 2];
        m_axi_awvalid = 1'b0;
        m_axi_wdata   = s_axi_wdata[grant_q*DATA_WIDTH +: DATA_WIDTH];
        m_axi_wstrb   = s_axi_wstrb[grant_q*SW +: SW];
        m_axi_wlast   = s_axi_wlast[grant_q];
        m_axi_wvalid  = 1'b0;
        m_axi_bready  = 1'b0;
        s_axi_awready = '0;
        s_axi_wready  = '0;
        s_axi_bid     = '0;
        s_axi_bresp   = '0;
        s_axi_bvalid  = '0;

        beat_next = beat_cnt_q + 9'd1;
        exp_beats = {1'b0, awlen_q} + 9'd1;

        case (state_q)
            IDLE: begin
                if (arb_found) begin
                    grant_d = arb_idx;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                m_axi_awvalid          = s_axi_awvalid[grant_q];
                s_axi_awready[grant_q] = m_axi_awready;
                if (m_axi_awvalid && m_axi_awready) begin
                    awlen_d    = m_axi_awlen;
                    beat_cnt_d = '0;
                    state_d    = DATA;
                end
            end
            DATA: begin
                m_axi_wvalid          = s_axi_wvalid[grant_q];
                s_axi_wready[grant_q] = m_axi_wready;
                if (m_axi_wvalid && m_axi_wready) begin
                    beat_cnt_d = beat_next;
                    // Burst runs until wlast either way; len_err only records the mismatch.
                    if (m_axi_wlast) begin
                        if (beat_next != exp_beats) len_err_d = 1'b1;
                        state_d = RESP;
                    end else if (beat_next == exp_beats) begin
                        len_err_d = 1'b1;
                    end
                end
            end
            RESP: begin
                s_axi_bid[grant_q*ID_WIDTH +: ID_WIDTH] = m_axi_bid;
                s_axi_bresp[grant_q*2 +: 2]             = m_axi_bresp;
                s_axi_bvalid[grant_q]                   = m_axi_bvalid;
                m_axi_bready                            = s_axi_bready[grant_q];
                if (m_axi_bvalid && m_axi_bready) begin
                    rr_ptr_d = (grant_q == LAST_IDX) ? '0 : grant_q + 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments and an async reset so every valid/ready
    // falls to zero the moment rst_n drops, without waiting for a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
            awlen_q    <= '0;
            len_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            awlen_q    <= awlen_d;
            len_err_q  <= len_err_d;
        end
    end

    assign grant_idx = grant_q;
    assign len_err   = len_err_q;

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Directed bench for axi_wr_arbiter: two requesters, stalled master, length errors, mid-burst reset.
module tb_axi_wr_arbiter;
    localparam int NR = 2;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int IW = 4;
    localparam int SW = DW / 8;

    logic clk = 1'b0;
    logic rst_n;

    logic [NR*IW-1:0] s_awid;
    logic [NR*AW-1:0] s_awaddr;
    logic [NR*8-1:0]  s_awlen;
    logic [NR*3-1:0]  s_awsize;
    logic [NR*2-1:0]  s_awburst;
    logic [NR-1:0]    s_awvalid, s_awready;
    logic [NR*DW-1:0] s_wdata;
    logic [NR*SW-1:0] s_wstrb;
    logic [NR-1:0]    s_wlast, s_wvalid, s_wready;
    logic [NR*IW-1:0] s_bid;
    logic [NR*2-1:0]  s_bresp;
    logic [NR-1:0]    s_bvalid, s_bready;
    logic [IW-1:0]    m_awid;
    logic [AW-1:0]    m_awaddr;
    logic [7:0]       m_awlen;
    logic [2:0]       m_awsize;
    logic [1:0]       m_awburst;
    logic             m_awvalid, m_awready;
    logic [DW-1:0]    m_wdata;
    logic [SW-1:0]    m_wstrb;
    logic             m_wlast, m_wvalid, m_wready;
    logic [IW-1:0]    m_bid;
    logic [1:0]       m_bresp;
    logic             m_bvalid, m_bready;
    logic             len_err;
    logic [0:0]       grant_idx;

    int n_cmp = 0;
    int n_bad = 0;
    logic exp_len_err;

    axi_wr_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axi_awid(s_awid), .s_axi_awaddr(s_awaddr), .s_axi_awlen(s_awlen),
        .s_axi_awsize(s_awsize), .s_axi_awburst(s_awburst), .s_axi_awvalid(s_awvalid),
        .s_axi_awready(s_awready),
        .s_axi_wdata(s_wdata), .s_axi_wstrb(s_wstrb), .s_axi_wlast(s_wlast),
        .s_axi_wvalid(s_wvalid), .s_axi_wready(s_wready),
        .s_axi_bid(s_bid), .s_axi_bresp(s_bresp), .s_axi_bvalid(s_bvalid), .s_axi_bready(s_bready),
        .m_axi_awid(m_awid), .m_axi_awaddr(m_awaddr), .m_axi_awlen(m_awlen),
        .m_axi_awsize(m_awsize), .m_axi_awburst(m_awburst), .m_axi_awvalid(m_awvalid),
        .m_axi_awready(m_awready),
        .m_axi_wdata(m_wdata), .m_axi_wstrb(m_wstrb), .m_axi_wlast(m_wlast),
        .m_axi_wvalid(m_wvalid), .m_axi_wready(m_wready),
        .m_axi_bid(m_bid), .m_axi_bresp(m_bresp), .m_axi_bvalid(m_bvalid), .m_axi_bready(m_bready),
        .len_err(len_err), .grant_idx(grant_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] beat_data(input int r, input int b);
        return {24'hD0A5C3, 8'(r), 16'h5A00, 8'(b * 17), 8'(~b)};
    endfunction

    function automatic logic [SW-1:0] beat_strb(input int b);
        return 8'hFF ^ 8'(b * 3);
    endfunction

    task automatic set_aw(input int r, input logic [IW-1:0] id, input logic [AW-1:0] addr,
                          input logic [7:0] len);
        s_awid[r*IW +: IW]   = id;
        s_awaddr[r*AW +: AW] = addr;
        s_awlen[r*8 +: 8]    = len;
        s_awsize[r*3 +: 3]   = 3'd3;
        s_awburst[r*2 +: 2]  = 2'b01;
        s_awvalid[r]         = 1'b1;
    endtask

    // Entered with the DUT in IDLE; drives one full write for requester r and checks every phase.
    task automatic run_txn(input int r, input logic [IW-1:0] id, input logic [AW-1:0] addr,
                           input logic [7:0] len, input int nbeats, input logic [1:0] bresp,
                           input int max_st, input bit keep_aw, input int abort_at);
        int waited;
        int st;
        logic [NR-1:0] onehot;
        onehot = NR'(1) << r;
        set_aw(r, id, addr, len);
        s_wdata[r*DW +: DW] = beat_data(r, 0);
        s_wstrb[r*SW +: SW] = beat_strb(0);
        s_wlast[r]          = (nbeats == 1);
        s_wvalid[r]         = 1'b1;
        m_wready            = 1'b1;
        m_awready           = 1'b0;
        waited = 0;
        do begin
            tick();
            waited++;
        end while (!m_awvalid && waited < 20);
        check("aw_latency", 64'(waited), 64'd1);
        check("grant_idx", 64'(grant_idx), 64'(r));
        check("m_awid", 64'(m_awid), 64'(id));
        check("m_awaddr", 64'(m_awaddr), 64'(addr));
        check("m_awlen", 64'(m_awlen), 64'(len));
        check("m_awsize_burst", {59'd0, m_awsize, m_awburst}, {59'd0, 3'd3, 2'b01});
        check("early_w_fwd", 64'(m_wvalid), 64'd0);
        check("early_wready", 64'(s_wready), 64'd0);
        st = (r + int'(len)) % (max_st + 1);
        repeat (st) begin
            check("aw_stall_ready", 64'(s_awready), 64'd0);
            tick();
            check("aw_hold", 64'(m_awvalid), 64'd1);
        end
        m_awready = 1'b1;
        #1;
        check("s_awready", 64'(s_awready), 64'(onehot));
        tick();
        m_awready = 1'b0;
        if (!keep_aw) s_awvalid[r] = 1'b0;

        for (int b = 0; b < nbeats; b++) begin
            s_wdata[r*DW +: DW] = beat_data(r, b);
            s_wstrb[r*SW +: SW] = beat_strb(b);
            s_wlast[r]          = (b == nbeats - 1);
            s_wvalid[r]         = 1'b1;
            if (b == abort_at) begin
                m_wready = 1'b1;
                return;
            end
            m_wready = 1'b0;
            #1;
            st = (2 * b + r + 1) % (max_st + 1);
            repeat (st) begin
                check("w_stall_wready", 64'(s_wready), 64'd0);
                check("w_stall_hold", 64'(m_wvalid), 64'd1);
                tick();
            end
            m_wready = 1'b1;
            #1;
            check("m_wvalid", 64'(m_wvalid), 64'd1);
            check("m_wdata", m_wdata, beat_data(r, b));
            check("m_wstrb", 64'(m_wstrb), 64'(beat_strb(b)));
            check("m_wlast", 64'(m_wlast), 64'(b == nbeats - 1));
            check("s_wready", 64'(s_wready), 64'(onehot));
            tick();
            if ((b == nbeats - 1) ? (b + 1 != int'(len) + 1) : (b + 1 == int'(len) + 1))
                exp_len_err = 1'b1;
            check("len_err", 64'(len_err), 64'(exp_len_err));
        end
        s_wvalid[r] = 1'b0;
        s_wlast[r]  = 1'b0;
        m_wready    = 1'b0;

        s_bready = ~onehot;
        #1;
        check("m_bready_gate", 64'(m_bready), 64'd0);
        check("w_after_last", 64'(m_wvalid), 64'd0);
        s_bready = onehot;
        m_bid    = id;
        m_bresp  = bresp;
        m_bvalid = 1'b0;
        #1;
        st = (r + nbeats) % (max_st + 1);
        repeat (st) begin
            check("b_stall_bready", 64'(m_bready), 64'd1);
            check("b_stall_bvalid", 64'(s_bvalid), 64'd0);
            tick();
        end
        m_bvalid = 1'b1;
        #1;
        check("s_bvalid", 64'(s_bvalid), 64'(onehot));
        check("s_bid", 64'(s_bid[r*IW +: IW]), 64'(id));
        check("s_bresp", 64'(s_bresp[r*2 +: 2]), 64'(bresp));
        tick();
        m_bvalid = 1'b0;
        s_bready = '0;
        check("idle_grant_hold", 64'(grant_idx), 64'(r));
        check("idle_awvalid", 64'(m_awvalid), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        s_awid = '0; s_awaddr = '0; s_awlen = '0; s_awsize = '0; s_awburst = '0; s_awvalid = '0;
        s_wdata = '0; s_wstrb = '0; s_wlast = '0; s_wvalid = '0; s_bready = '0;
        m_awready = 1'b0; m_wready = 1'b0; m_bid = '0; m_bresp = '0; m_bvalid = 1'b0;
        exp_len_err = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_s_awready", 64'(s_awready), 64'd0);
        check("rst_s_wready", 64'(s_wready), 64'd0);
        check("rst_s_bvalid", 64'(s_bvalid), 64'd0);
        check("rst_m_valids", {61'd0, m_awvalid, m_wvalid, m_bready}, 64'd0);
        check("rst_len_err", 64'(len_err), 64'd0);
        check("rst_grant_idx", 64'(grant_idx), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Both requesters hold awvalid: grants alternate 0,1,0,1.
        set_aw(1, 4'h1, 32'h2000_0000, 8'd1);
        run_txn(0, 4'h0, 32'h1000_0000, 8'd1, 2, 2'b00, 2, 1'b1, -1);
        run_txn(1, 4'h1, 32'h2000_0000, 8'd1, 2, 2'b01, 3, 1'b1, -1);
        run_txn(0, 4'h0, 32'h1000_0000, 8'd1, 2, 2'b10, 4, 1'b0, -1);
        run_txn(1, 4'h1, 32'h2000_0000, 8'd1, 2, 2'b11, 5, 1'b0, -1);

        // Single requester 0, awlen=3, four beats.
        run_txn(0, 4'h5, 32'h0000_1000, 8'd3, 4, 2'b00, 3, 1'b0, -1);
        check("single_len_err", 64'(len_err), 64'd0);

        // rr_ptr now 1: requester 1 wins even with 0 requesting; awlen=1 but 3 beats.
        set_aw(0, 4'h6, 32'h3000_0000, 8'd0);
        run_txn(1, 4'h7, 32'h4000_0000, 8'd1, 3, 2'b10, 5, 1'b0, -1);
        check("len_err_set", 64'(len_err), 64'd1);
        run_txn(0, 4'h6, 32'h3000_0000, 8'd0, 1, 2'b01, 5, 1'b0, -1);
        check("len_err_sticky", 64'(len_err), 64'd1);

        // Reset while requester 1 is in DATA after 2 of 8 beats.
        run_txn(1, 4'h9, 32'h5000_0000, 8'd7, 8, 2'b00, 2, 1'b0, 2);
        #1;
        check("pre_rst_wvalid", 64'(m_wvalid), 64'd1);
        set_aw(0, 4'hA, 32'h6000_0000, 8'd1);
        s_awvalid = '1;
        m_awready = 1'b1;
        m_bvalid  = 1'b1;
        s_bready  = '1;
        rst_n = 1'b0;
        #1;
        check("async_rst_s_awready", 64'(s_awready), 64'd0);
        check("async_rst_s_wready", 64'(s_wready), 64'd0);
        check("async_rst_s_bvalid", 64'(s_bvalid), 64'd0);
        check("async_rst_m_valids", {61'd0, m_awvalid, m_wvalid, m_bready}, 64'd0);
        check("async_rst_len_err", 64'(len_err), 64'd0);
        check("async_rst_grant", 64'(grant_idx), 64'd0);
        exp_len_err = 1'b0;
        tick();
        check("rst_hold_awready", 64'(s_awready), 64'd0);
        s_awvalid = '0; s_wvalid = '0; s_wlast = '0; s_bready = '0;
        m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        set_aw(1, 4'h9, 32'h5000_0000, 8'd7);
        run_txn(0, 4'hA, 32'h6000_0000, 8'd1, 2, 2'b00, 1, 1'b0, -1);
        s_awvalid[1] = 1'b0;
        check("post_rst_len_err", 64'(len_err), 64'd0);
        repeat (2) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
